// File: rtl/arvi_mem_pkg.sv
// arvi_mem_pkg: shared FSM, grant and bus-op types for the memory arbiter
// and any future bus masters on the shared memory bus.
package arvi_mem_pkg;

    localparam int BUS_XLEN = 32;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef enum logic {GNT_IC, GNT_DM} gnt_t;

    typedef struct packed {
        logic                    we;
        logic [BUS_XLEN-1:0]     addr;
        logic [BUS_XLEN-1:0]     wdata;
        logic [BUS_XLEN/8-1:0]   be;
    } bus_op_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts unacknowledged bus cycles and flags the cycle that
// would reach LIMIT; used by mem_arbiter only with ARVI_MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            cnt <= '0;
        else if (i_en)
            cnt <= cnt + 1'b1;
    end

    // Fires in the LIMIT-th waiting cycle so the bus is held exactly LIMIT cycles.
    assign o_timeout = i_en && cnt == W'(LIMIT - 1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority I-cache/data-port arbiter onto one memory bus.
// Optional bus-ack watchdog enabled by defining ARVI_MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import arvi_mem_pkg::*;
#(
    parameter int XLEN           = BUS_XLEN,
    parameter bit DATA_PRIORITY  = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ic_req,
    input  logic [XLEN-1:0]   i_ic_addr,
    output logic              o_ic_ready,
    output logic [XLEN-1:0]   o_ic_data,
    input  logic              i_dm_rd,
    input  logic              i_dm_wr,
    input  logic [XLEN-1:0]   i_dm_addr,
    input  logic [XLEN-1:0]   i_dm_wdata,
    input  logic [XLEN/8-1:0] i_dm_be,
    output logic              o_dm_ready,
    output logic [XLEN-1:0]   o_dm_rdata,
    output logic              o_dm_err,
    output logic              o_ic_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [XLEN-1:0]   o_bus_addr,
    output logic [XLEN-1:0]   o_bus_wdata,
    output logic [XLEN/8-1:0] o_bus_be,
    input  logic              i_bus_ack,
    input  logic [XLEN-1:0]   i_bus_rdata
);

    state_t  state;
    gnt_t    gnt;
    bus_op_t op;
    logic    timeout;
    logic    dm_req;
    logic    win_dm;

    assign dm_req = i_dm_rd | i_dm_wr;
    assign win_dm = dm_req && (DATA_PRIORITY || !i_ic_req);

    assign o_bus_we    = op.we;
    assign o_bus_addr  = op.addr;
    assign o_bus_wdata = op.wdata;
    assign o_bus_be    = op.be;

`ifdef ARVI_MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (state != BUS),
        .i_en      (state == BUS && !i_bus_ack),
        .o_timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            gnt        <= GNT_IC;
            op         <= '0;
            o_bus_req  <= 1'b0;
            o_ic_ready <= 1'b0;
            o_dm_ready <= 1'b0;
            o_ic_err   <= 1'b0;
            o_dm_err   <= 1'b0;
            o_ic_data  <= '0;
            o_dm_rdata <= '0;
        end else begin
            o_ic_ready <= 1'b0;
            o_dm_ready <= 1'b0;
            o_ic_err   <= 1'b0;
            o_dm_err   <= 1'b0;
            case (state)
                IDLE: if (i_ic_req || dm_req) begin
                    gnt       <= win_dm ? GNT_DM : GNT_IC;
                    op.we     <= win_dm && i_dm_wr;
                    op.addr   <= win_dm ? i_dm_addr : i_ic_addr;
                    op.wdata  <= win_dm ? i_dm_wdata : '0;
                    op.be     <= (win_dm && i_dm_wr) ? i_dm_be : '1;
                    o_bus_req <= 1'b1;
                    state     <= BUS;
                end
                // timeout is never asserted together with an ack
                BUS: if (i_bus_ack || timeout) begin
                    o_bus_req <= 1'b0;
                    state     <= RESP;
                    if (gnt == GNT_DM) begin
                        o_dm_ready <= 1'b1;
                        o_dm_err   <= timeout;
                        o_dm_rdata <= (op.we || timeout) ? '0 : i_bus_rdata;
                    end else begin
                        o_ic_ready <= 1'b1;
                        o_ic_err   <= timeout;
                        o_ic_data  <= timeout ? '0 : i_bus_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Downstream of the single-cycle datapath. Merges the instruction-cache refill port and the data-memory port onto one shared memory bus, one transaction at a time. Each master gets a single-cycle ready pulse with registered read data. A fixed-priority FSM holds the bus request stable until the slave acks.

Parameters:
XLEN, 32, address/data width
DATA_PRIORITY, 1, 1: data port wins simultaneous requests; 0: instruction port wins
TIMEOUT_CYCLES, 255, bus-ack watchdog limit; used only with the optional feature

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, synchronous, active-high
i_ic_req  in  1  instruction refill request, level, held until o_ic_ready
i_ic_addr  in  XLEN  refill word address
o_ic_ready  out  1  one-cycle completion pulse to the I-cache
o_ic_data  out  XLEN  refill data, valid while o_ic_ready=1
i_dm_rd  in  1  data read request, level
i_dm_wr  in  1  data write request, level
i_dm_addr  in  XLEN  data address
i_dm_wdata  in  XLEN  write data
i_dm_be  in  XLEN/8  write byte enables
o_dm_ready  out  1  one-cycle completion pulse to the data port
o_dm_rdata  out  XLEN  read data, valid while o_dm_ready=1
o_dm_err  out  1  bus error pulse, coincident with o_dm_ready (optional feature only, else tied 0)
o_ic_err  out  1  same for the instruction port
o_bus_req  out  1  bus transaction valid
o_bus_we  out  1  1=write
o_bus_addr  out  XLEN  bus address
o_bus_wdata  out  XLEN  bus write data
o_bus_be  out  XLEN/8  bus byte enables (all ones for reads)
i_bus_ack  in  1  slave completion; may arrive in the same cycle as o_bus_req
i_bus_rdata  in  XLEN  valid with i_bus_ack

Behaviour:
- FSM states and transitions:
  - IDLE: if any request is pending, latch grant, op, addr, wdata and be, then go to BUS.
  - BUS: o_bus_req=1 with latched fields held. On i_bus_ack, latch i_bus_rdata and go to RESP.
  - RESP: pulse the granted master's ready, then go to IDLE.
- All outputs are registered or decoded from registered state. Nothing is combinational from request inputs.
- Latency: request sampled in IDLE at cycle 0, o_bus_req at cycle 1, ack at cycle k≥1, ready at k+1, IDLE at k+2. Minimum 3 cycles per transaction.
- The RESP state guarantees that a request still high in the cycle after ready is treated as a new transaction. Masters must drop or change the request after ready.
- Arbitration: a data request is i_dm_rd|i_dm_wr. On a tie, DATA_PRIORITY selects the winner. The loser stays pending and is served next, with no starvation check.
- i_dm_rd and i_dm_wr both high: treated as a write.
- Write completion: o_dm_rdata=0.
- The non-granted master's ready stays 0 throughout.
- Request inputs changing while in BUS: ignored; the latched copy is used.
- i_bus_ack in IDLE or RESP: ignored.
- Reset values: state=IDLE; all o_* = 0; latched fields = 0.
- Reset mid-transaction: o_bus_req drops on the next edge. No ready pulse is generated for the aborted request.

Optional Feature:
- Macro: ARVI_MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with data=0 and the granted master's err asserted alongside ready.
  - The bus request is dropped.
- Without the macro: no counter, err outputs tied 0, BUS waits indefinitely.

Decomposition:
- Package arvi_mem_pkg holds:
  - the FSM state enum (IDLE, BUS, RESP)
  - the grant enum (GNT_IC, GNT_DM)
  - a packed bus-op struct (we, addr, wdata, be), reused by future bus masters
- Sub-module mem_arb_watchdog (counter, clear, timeout flag) is instantiated only under the macro.

Test Plan:
- IC-only: i_ic_req, addr 0x100, slave acks on the first bus cycle with 0x00000013 -> o_bus_req cycles 1-1, o_ic_ready=1 at cycle 2 with o_ic_data=0x00000013, o_dm_ready stays 0.
- Simultaneous: i_ic_req (0x200) and i_dm_rd (0x8000), DATA_PRIORITY=1, ack after 2 wait cycles -> data served first (o_bus_addr=0x8000, o_bus_we=0), then IC (0x200). Exactly one ready pulse each, in that order.
- Write: i_dm_wr, addr 0x10, wdata 0xDEADBEEF, be 4'b0011 -> o_bus_we=1 with be 4'b0011 and data held stable through 5 wait cycles; o_dm_ready one cycle after ack with rdata=0.
- Reset mid-BUS: i_rst high for 1 cycle during wait -> o_bus_req=0 next cycle; no ready pulse; a late ack is ignored; next request is served normally.
- Back-to-back: master keeps i_dm_rd high one cycle after ready -> a second bus transaction is issued (documented re-request behaviour).
- Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> after 4 BUS cycles, o_dm_ready=1, o_dm_err=1, o_dm_rdata=0, o_bus_req dropped.
